frame_buf_ring: RTL and testbench
=================================

Name: frame_buf_ring

Overview:
- Single-clock, N-buffer ring frame buffer; successor to the single-buffer frame buffer.
- Writer fills whole frames into a ring of NUM_BUFS slots while the reader drains completed frames in order.
- Adds per-slot full/empty tracking, flow-control outputs, frame markers, an overflow flag, and an optional repeat-last-frame mode for display refresh.
- Sits between the pixel source and the display/serializer path.

Parameters:
- DATA_WIDTH, 24, bits per pixel word.
- ADDR_WIDTH, 3, address bits within one frame; FRAME_LEN = 1 << ADDR_WIDTH words.
- BUF_BITS, 1, slot index bits; NUM_BUFS = 1 << BUF_BITS (default 2, ping-pong).

Ports:
- clk  in  1  single clock for all logic and memory.
- reset  in  1  synchronous, active-low reset (asserted = 0).
- wr_en_in  in  1  active-low write strobe; data_in is accepted when wr_en_in = 0 and wr_rdy = 1.
- data_in  in  DATA_WIDTH  write pixel.
- wr_rdy  out  1  current write slot is not full.
- wr_frame_done  out  1  one-cycle pulse after the last word of a frame is written.
- overflow  out  1  sticky; set when a write is attempted with wr_rdy = 0.
- rd_en_in  in  1  active-low read request.
- data_out  out  DATA_WIDTH  read pixel, registered.
- rd_valid  out  1  data_out is valid this cycle.
- rd_first  out  1  data_out is word 0 of a frame (qualified by rd_valid).
- rd_last  out  1  data_out is word FRAME_LEN-1 (qualified by rd_valid).
- rep_en  in  1  active-high repeat-last-frame mode.
- num_full  out  BUF_BITS+1  count of full slots, 0..NUM_BUFS.

Behaviour:
- Reset (reset = 0 at clk edge), all of the following clear:
  - wr_slot, rd_slot, wr_addr, rd_addr, num_full, all slot-full bits.
  - overflow, wr_frame_done, rd_valid, rd_first, rd_last, data_out.
  - wr_rdy = 1 on the first cycle after reset.
  - Reset mid-frame discards partial and completed frames. Memory contents are not cleared.
- Storage:
  - Memory depth is NUM_BUFS*FRAME_LEN.
  - Physical address = {slot, addr}.
  - Synchronous write; registered read with 1-cycle latency.
- Write FSM, states IDLE and FILL:
  - IDLE:
    - wr_addr = 0.
    - An accepted write stores the word at {wr_slot, 0}, sets wr_addr = 1 and goes to FILL.
  - FILL:
    - Each accepted write stores at {wr_slot, wr_addr} and increments wr_addr.
    - The cycle with no write holds state.
    - When the write at wr_addr = FRAME_LEN-1 is accepted:
      - Set the full bit of wr_slot and increment num_full.
      - Pulse wr_frame_done the next cycle.
      - wr_slot <= wr_slot+1, wrapping modulo NUM_BUFS.
      - Return to IDLE.
  - Write with wr_rdy = 0: the word is dropped, overflow <= 1, and no address or state changes.
- Read FSM, states IDLE and READ:
  - IDLE: leaves to READ when rd_en_in = 0 and the full bit of rd_slot is set. The first read issues at {rd_slot, 0}.
  - READ:
    - Each cycle with rd_en_in = 0 issues a read and increments rd_addr.
    - rd_en_in = 1 pauses the FSM with no issue.
  - Output timing:
    - rd_valid is high the cycle after each issued read.
    - rd_first and rd_last track the issued address delayed by one cycle.
  - After the issue at rd_addr = FRAME_LEN-1, one of two cases applies:
    - If rep_en = 1 and num_full = 1 (no newer frame waiting): the slot is retained, rd_slot is unchanged, and the FSM returns to IDLE, so the same frame replays.
    - Otherwise: clear the full bit of rd_slot, decrement num_full, set rd_slot <= rd_slot+1 (wrapping), and return to IDLE.
  - A read request with no full slot is ignored; rd_valid stays 0.
- Simultaneous events:
  - A write-frame completion and a read-slot release in the same cycle leave num_full unchanged. Both slot bits update.
  - Writer and reader on the same slot cannot occur: the writer requires the slot empty, and the reader requires it full.
- wr_rdy:
  - wr_rdy = NOT full[wr_slot], registered, consistent with the updates of the same cycle.
  - When num_full = NUM_BUFS, wr_rdy = 0.
- Width rules:
  - Address and slot counters wrap naturally at their widths.
  - num_full never exceeds NUM_BUFS and never goes below 0.

Decomposition:
- Shared package: IDLE/FILL/READ state encodings and the ASSERT/DEASSERT (active-low) constants.
- One sub-module: the existing data_mem, instantiated with ADDR_WIDTH+BUF_BITS address bits and clocked on clk.
- Slot bookkeeping and both FSMs stay in frame_buf_ring.

Test Plan:
1. Reset, then write 8 words 0x000001..0x000008 with continuous strobes -> wr_frame_done pulses once, num_full = 1, wr_rdy = 1.
2. After test 1, hold rd_en_in = 0 for 9 cycles -> data_out = 1..8 on consecutive rd_valid cycles, rd_first on 1, rd_last on 8, num_full = 0.
3. Write 2 frames (A = 0x10.., B = 0x20..) with no reads -> num_full = 2, wr_rdy = 0. Then a 9th write -> overflow = 1, and frame A still reads back intact.
4. rep_en = 1, one frame C written, read twice -> C is output twice and num_full stays 1. Then write frame D -> the next read outputs D, and C's slot is released.
5. Read frame A while writing frame B; the last read issue and the last write land on the same clk -> num_full stays 1 and wr_rdy stays 1.
6. Assert reset = 0 after 4 words written and during an active read -> all outputs clear next cycle, num_full = 0. A fresh 8-word frame then reads back correctly from slot 0.

Source files
------------

// File: rtl/frame_buf_ring_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_ring_pkg
// Description : Shared definitions for the ring frame buffer. Holds the FSM
//               state encodings used by the write and read controllers and
//               the polarity constants for the active-low strobes and reset.
// Ports       : none (package)
// Revision    : 1.0 - initial ring-buffer release
// ============================================================================
package frame_buf_ring_pkg;

  // Both controllers share one encoding: write uses IDLE/FILL, read uses IDLE/READ.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    READ = 2'd2
  } state_t;

  // Strobes and reset are active-low.
  localparam logic ASSERT   = 1'b0;
  localparam logic DEASSERT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/frame_buf_ring_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_ring_if
// Description : Pixel bus between the source/sink and the ring frame buffer.
// Ports       : master - drives wr_en_in, data_in, rd_en_in, rep_en;
//                        observes wr_rdy, wr_frame_done, overflow, data_out,
//                        rd_valid, rd_first, rd_last, num_full
//               slave  - the frame buffer side (directions reversed)
// Revision    : 1.0 - initial ring-buffer release
// ============================================================================
interface frame_buf_ring_if #(
  parameter int DATA_WIDTH = 24,
  parameter int BUF_BITS   = 1
);
  logic                  wr_en_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_rdy;
  logic                  wr_frame_done;
  logic                  overflow;
  logic                  rd_en_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  rd_first;
  logic                  rd_last;
  logic                  rep_en;
  logic [BUF_BITS:0]     num_full;

  modport master (
    output wr_en_in, data_in, rd_en_in, rep_en,
    input  wr_rdy, wr_frame_done, overflow, data_out,
           rd_valid, rd_first, rd_last, num_full
  );

  modport slave (
    input  wr_en_in, data_in, rd_en_in, rep_en,
    output wr_rdy, wr_frame_done, overflow, data_out,
           rd_valid, rd_first, rd_last, num_full
  );
endinterface
`default_nettype wire

// File: rtl/frame_buf_ring_data_mem.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_ring_data_mem
// Description : Simple dual-port RAM, synchronous write, registered read
//               with one cycle of latency. Only the read register is reset;
//               the array contents survive reset.
// Ports       : clk, reset (sync, active-low), we/waddr/wdata write port,
//               re/raddr read port, rdata registered read data
// Revision    : 1.0 - initial ring-buffer release
// ============================================================================
module frame_buf_ring_data_mem
  import frame_buf_ring_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset == ASSERT) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end
endmodule
`default_nettype wire

// File: rtl/frame_buf_ring.sv
`default_nettype none
// ============================================================================
// Module      : frame_buf_ring
// Description : N-slot ring frame buffer. The writer fills whole frames into
//               successive slots; the reader drains completed frames in
//               order, optionally replaying the last frame when no newer one
//               is waiting (display refresh).
// Ports       : clk   - single clock
//               reset - synchronous, active-low
//               bus   - frame_buf_ring_if.slave (write strobe/data, ready,
//                       frame-done, overflow, read request, read data with
//                       valid/first/last markers, repeat enable, fill count)
// Revision    : 1.0 - initial ring-buffer release
// ============================================================================
module frame_buf_ring
  import frame_buf_ring_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 3,
  parameter int BUF_BITS   = 1
) (
  input  logic            clk,
  input  logic            reset,
  frame_buf_ring_if.slave bus
);
  localparam int                    NUM_BUFS  = 1 << BUF_BITS;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [BUF_BITS:0]     ONE_FULL  = (BUF_BITS+1)'(1);

  state_t                wr_state, wr_state_nxt;
  state_t                rd_state, rd_state_nxt;
  logic [BUF_BITS-1:0]   wr_slot, wr_slot_nxt;
  logic [BUF_BITS-1:0]   rd_slot, rd_slot_nxt;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_addr_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr, rd_addr_nxt;
  logic [NUM_BUFS-1:0]   full, full_nxt;
  logic [BUF_BITS:0]     num_full, num_full_nxt;
  logic                  wr_rdy_q, wr_rdy_nxt;
  logic                  wr_frame_done_q, overflow_q;
  logic                  rd_valid_q, rd_first_q, rd_last_q;

  logic wr_try, wr_acc, wr_done;
  logic rd_req, rd_issue, rd_end, rd_keep, rd_release;

  assign wr_try  = (bus.wr_en_in == ASSERT);
  assign wr_acc  = wr_try && wr_rdy_q;
  assign wr_done = wr_acc && (wr_state == FILL) && (wr_addr == ADDR_LAST);

  assign rd_req   = (bus.rd_en_in == ASSERT);
  assign rd_issue = rd_req && (rd_state == READ);
  assign rd_end   = rd_issue && (rd_addr == ADDR_LAST);
  // Replay only when this is the sole completed frame; a newer one wins.
  assign rd_keep    = bus.rep_en && (num_full == ONE_FULL);
  assign rd_release = rd_end && !rd_keep;

  // ---------------- write controller ----------------
  always_comb begin
    wr_state_nxt = wr_state;
    wr_addr_nxt  = wr_addr;
    wr_slot_nxt  = wr_slot;
    case (wr_state)
      IDLE: begin
        wr_addr_nxt = '0;
        if (wr_acc) begin
          wr_addr_nxt  = ADDR_ONE;
          wr_state_nxt = FILL;
        end
      end
      FILL: begin
        if (wr_acc) begin
          if (wr_addr == ADDR_LAST) begin
            wr_addr_nxt  = '0;
            wr_slot_nxt  = wr_slot + 1'b1;
            wr_state_nxt = IDLE;
          end else begin
            wr_addr_nxt = wr_addr + 1'b1;
          end
        end
      end
      default: begin
        wr_addr_nxt  = '0;
        wr_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------- read controller ----------------
  always_comb begin
    rd_state_nxt = rd_state;
    rd_addr_nxt  = rd_addr;
    rd_slot_nxt  = rd_slot;
    case (rd_state)
      IDLE: begin
        rd_addr_nxt = '0;
        if (rd_req && full[rd_slot]) begin
          rd_state_nxt = READ;
        end
      end
      READ: begin
        if (rd_req) begin
          if (rd_addr == ADDR_LAST) begin
            rd_addr_nxt  = '0;
            rd_state_nxt = IDLE;
            if (rd_release) begin
              rd_slot_nxt = rd_slot + 1'b1;
            end
          end else begin
            rd_addr_nxt = rd_addr + 1'b1;
          end
        end
      end
      default: begin
        rd_addr_nxt  = '0;
        rd_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------- slot bookkeeping ----------------
  // A completion and a release in the same cycle touch different slots
  // (writer needs an empty slot, reader a full one), so both bits update
  // and the count nets to zero change.
  always_comb begin
    full_nxt = full;
    if (wr_done) begin
      full_nxt[wr_slot] = 1'b1;
    end
    if (rd_release) begin
      full_nxt[rd_slot] = 1'b0;
    end
    num_full_nxt = num_full;
    case ({wr_done, rd_release})
      2'b10:   num_full_nxt = num_full + 1'b1;
      2'b01:   num_full_nxt = num_full - 1'b1;
      default: num_full_nxt = num_full;
    endcase
    // Registered ready reflects the slot the writer will target next cycle.
    wr_rdy_nxt = !full_nxt[wr_slot_nxt];
  end

  always_ff @(posedge clk) begin
    if (reset == ASSERT) begin
      wr_state        <= IDLE;
      rd_state        <= IDLE;
      wr_slot         <= '0;
      rd_slot         <= '0;
      wr_addr         <= '0;
      rd_addr         <= '0;
      full            <= '0;
      num_full        <= '0;
      wr_rdy_q        <= 1'b1;
      wr_frame_done_q <= 1'b0;
      overflow_q      <= 1'b0;
      rd_valid_q      <= 1'b0;
      rd_first_q      <= 1'b0;
      rd_last_q       <= 1'b0;
    end else begin
      wr_state        <= wr_state_nxt;
      rd_state        <= rd_state_nxt;
      wr_slot         <= wr_slot_nxt;
      rd_slot         <= rd_slot_nxt;
      wr_addr         <= wr_addr_nxt;
      rd_addr         <= rd_addr_nxt;
      full            <= full_nxt;
      num_full        <= num_full_nxt;
      wr_rdy_q        <= wr_rdy_nxt;
      wr_frame_done_q <= wr_done;
      overflow_q      <= overflow_q | (wr_try & ~wr_rdy_q);
      rd_valid_q      <= rd_issue;
      rd_first_q      <= rd_issue && (rd_addr == '0);
      rd_last_q       <= rd_end;
    end
  end

  frame_buf_ring_data_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH + BUF_BITS)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr ({wr_slot, wr_addr}),
    .wdata (bus.data_in),
    .re    (rd_issue),
    .raddr ({rd_slot, rd_addr}),
    .rdata (bus.data_out)
  );

  assign bus.wr_rdy        = wr_rdy_q;
  assign bus.wr_frame_done = wr_frame_done_q;
  assign bus.overflow      = overflow_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_first      = rd_first_q;
  assign bus.rd_last       = rd_last_q;
  assign bus.num_full      = num_full;
endmodule
`default_nettype wire

// File: tb/tb_frame_buf_ring.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_buf_ring
// Description : Directed self-checking bench for frame_buf_ring (2 slots,
//               8-word frames, 24-bit pixels).
// Ports       : none
// Revision    : 1.0 - initial ring-buffer release
// ============================================================================
module tb_frame_buf_ring;
  import frame_buf_ring_pkg::*;

  localparam int DW = 24;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total  = 0;

  frame_buf_ring_if #(.DATA_WIDTH(DW), .BUF_BITS(1)) bus ();

  frame_buf_ring #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (3),
    .BUF_BITS   (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_rd(input logic [DW-1:0] base, input string tag, inout int k);
    if (bus.rd_valid === 1'b1) begin
      chk($sformatf("%s_d%0d", tag, k), {8'h0, bus.data_out}, {8'h0, base + DW'(k)});
      chk($sformatf("%s_fl%0d", tag, k), {30'h0, bus.rd_first, bus.rd_last},
          {30'h0, (k == 0), (k == 7)});
      k++;
    end
  endtask

  task automatic write_frame(input logic [DW-1:0] base, input string tag);
    int done = 0;
    for (int i = 0; i < 8; i++) begin
      bus.wr_en_in = ASSERT;
      bus.data_in  = base + DW'(i);
      step();
      if (bus.wr_frame_done === 1'b1) done++;
    end
    bus.wr_en_in = DEASSERT;
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic read_frame(input logic [DW-1:0] base, input string tag);
    int k = 0;
    bus.rd_en_in = ASSERT;
    repeat (9) begin
      step();
      sample_rd(base, tag, k);
    end
    bus.rd_en_in = DEASSERT;
    step();
    sample_rd(base, tag, k);
    chk({tag, "_cnt"}, k, 8);
  endtask

  // Read one frame while writing another; writes occupy cycles s+1..s+8.
  task automatic rw_frame(input logic [DW-1:0] rbase, input logic [DW-1:0] wbase,
                          input int s, input string tag);
    int k = 0;
    int done = 0;
    for (int c = 1; c <= 9; c++) begin
      bus.rd_en_in = ASSERT;
      if (c > s && c <= s + 8) begin
        bus.wr_en_in = ASSERT;
        bus.data_in  = wbase + DW'(c - s - 1);
      end else begin
        bus.wr_en_in = DEASSERT;
      end
      step();
      sample_rd(rbase, tag, k);
      if (bus.wr_frame_done === 1'b1) done++;
    end
    bus.rd_en_in = DEASSERT;
    bus.wr_en_in = DEASSERT;
    chk({tag, "_wdone"}, done, 1);
    chk({tag, "_nf_end"}, {29'h0, bus.num_full}, 1);
    chk({tag, "_rdy_end"}, {31'h0, bus.wr_rdy}, 1);
    step();
    sample_rd(rbase, tag, k);
    chk({tag, "_cnt"}, k, 8);
  endtask

  initial begin
    int v;
    reset        = ASSERT;
    bus.wr_en_in = DEASSERT;
    bus.rd_en_in = DEASSERT;
    bus.data_in  = '0;
    bus.rep_en   = 1'b0;
    repeat (2) step();

    // Reset state
    chk("rst_rdy", {31'h0, bus.wr_rdy}, 1);
    chk("rst_nf", {29'h0, bus.num_full}, 0);
    chk("rst_flags", {28'h0, bus.rd_valid, bus.rd_first, bus.rd_last, bus.overflow}, 0);
    chk("rst_done", {31'h0, bus.wr_frame_done}, 0);
    reset = DEASSERT;

    // 1: one frame written
    write_frame(24'h000001, "t1");
    chk("t1_nf", {29'h0, bus.num_full}, 1);
    chk("t1_rdy", {31'h0, bus.wr_rdy}, 1);

    // 2: drain it
    read_frame(24'h000001, "t2");
    chk("t2_nf", {29'h0, bus.num_full}, 0);
    // read request with nothing full is ignored
    v = 0;
    bus.rd_en_in = ASSERT;
    repeat (3) begin
      step();
      if (bus.rd_valid !== 1'b0) v++;
    end
    bus.rd_en_in = DEASSERT;
    chk("t2_empty_rd", v, 0);

    // 3: fill both slots, then overflow
    write_frame(24'h000010, "t3a");
    write_frame(24'h000020, "t3b");
    chk("t3_nf", {29'h0, bus.num_full}, 2);
    chk("t3_rdy", {31'h0, bus.wr_rdy}, 0);
    bus.wr_en_in = ASSERT;
    bus.data_in  = 24'hBADBAD;
    step();
    bus.wr_en_in = DEASSERT;
    chk("t3_ovf", {31'h0, bus.overflow}, 1);
    chk("t3_nf_ovf", {29'h0, bus.num_full}, 2);
    read_frame(24'h000010, "t3ra");
    chk("t3_nf_a", {29'h0, bus.num_full}, 1);
    read_frame(24'h000020, "t3rb");
    chk("t3_nf_b", {29'h0, bus.num_full}, 0);
    chk("t3_ovf_sticky", {31'h0, bus.overflow}, 1);

    // 4: repeat mode
    bus.rep_en = 1'b1;
    write_frame(24'h000030, "t4c");
    read_frame(24'h000030, "t4r1");
    chk("t4_nf_keep", {29'h0, bus.num_full}, 1);
    // second replay of C while D arrives -> C released at its end
    rw_frame(24'h000030, 24'h000040, 0, "t4r2");
    read_frame(24'h000040, "t4rd");
    chk("t4_nf_d", {29'h0, bus.num_full}, 1);
    bus.rep_en = 1'b0;
    read_frame(24'h000040, "t4rd2");
    chk("t4_nf_0", {29'h0, bus.num_full}, 0);

    // 5: last read issue and last write on the same edge
    write_frame(24'h000050, "t5a");
    rw_frame(24'h000050, 24'h000060, 1, "t5");

    // 6: reset mid-write and mid-read
    for (int c = 0; c < 4; c++) begin
      bus.rd_en_in = ASSERT;
      bus.wr_en_in = ASSERT;
      bus.data_in  = 24'h000099 + DW'(c);
      step();
    end
    chk("t6_active", {31'h0, bus.rd_valid}, 1);
    reset = ASSERT;
    step();
    chk("t6_flags", {28'h0, bus.rd_valid, bus.rd_first, bus.rd_last, bus.overflow}, 0);
    chk("t6_data", {8'h0, bus.data_out}, 0);
    chk("t6_nf", {29'h0, bus.num_full}, 0);
    chk("t6_rdy", {31'h0, bus.wr_rdy}, 1);
    reset        = DEASSERT;
    bus.rd_en_in = DEASSERT;
    bus.wr_en_in = DEASSERT;
    step();
    write_frame(24'h000070, "t6w");
    read_frame(24'h000070, "t6r");
    chk("t6_nf_end", {29'h0, bus.num_full}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
